// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller slice.
package irq_pkg;

   // Request/handler sequencing states seen by the decoder handshake
   typedef enum logic [1:0] {
      IRQ_IDLE,
      IRQ_REQ,
      IRQ_SERVICE
   } irq_state_t;

   // Decoder irq_num is one bit wide, so two lines is the natural default
   localparam int IRQ_NUM_W_DEFAULT = 1;
   localparam int NUM_IRQS_DEFAULT  = 2;

   // Fewer than two flops does not give a metastable sample time to settle
   localparam int SYNC_STAGES_MIN   = 2;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one asynchronous peripheral interrupt line.
module irq_sync
   import irq_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_MIN
) (
   input  logic clk,
   input  logic reset_n_i,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] chain_q;

   // Shift the raw line through the chain; only the last flop is used downstream
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], async_i};
      end
   end

   assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: synchronises peripheral lines, keeps pending/mask state,
// picks the lowest-index enabled line and hands it to the decoder with a
// request / service / end-of-interrupt handshake. One request or handler at a time.
module irq_controller
   import irq_pkg::*;
#(
   parameter int                  NUM_IRQS    = NUM_IRQS_DEFAULT,
   parameter int                  IRQ_NUM_W   = IRQ_NUM_W_DEFAULT,
   parameter logic [NUM_IRQS-1:0] EDGE_MASK   = '1,
   parameter int                  SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n_i,
   input  logic [NUM_IRQS-1:0]  irq_lines_i,
   input  logic                 mask_we_i,
   input  logic [NUM_IRQS-1:0]  mask_i,
   input  logic                 en_i,
   input  logic                 eoi_i,
   output logic                 irq_o,
   output logic [IRQ_NUM_W-1:0] irq_num_o,
   output logic [NUM_IRQS-1:0]  pending_o,
   output logic                 in_service_o
);

   logic [NUM_IRQS-1:0]  sync_w;
   logic [NUM_IRQS-1:0]  level_q;
   logic [NUM_IRQS-1:0]  hist_q;
   logic [NUM_IRQS-1:0]  rise;
   logic [NUM_IRQS-1:0]  pending_q;
   logic [NUM_IRQS-1:0]  pending_d;
   logic [NUM_IRQS-1:0]  mask_q;
   logic [NUM_IRQS-1:0]  cand;
   logic [NUM_IRQS-1:0]  clear;
   logic [IRQ_NUM_W-1:0] win_num;
   logic                 accept;

   irq_state_t           state_q;
   irq_state_t           state_d;
   logic                 irq_q;
   logic                 irq_d;
   logic [IRQ_NUM_W-1:0] num_q;
   logic [IRQ_NUM_W-1:0] num_d;
   logic                 svc_q;
   logic                 svc_d;

   for (genvar gi = 0; gi < NUM_IRQS; gi++) begin : g_sync
      irq_sync #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk       (clk),
         .reset_n_i (reset_n_i),
         .async_i   (irq_lines_i[gi]),
         .sync_o    (sync_w[gi])
      );
   end

   // Retime the synchronised level and keep a one-cycle history for edge detection
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         level_q <= '0;
         hist_q  <= '0;
      end else begin
         level_q <= sync_w;
         hist_q  <= level_q;
      end
   end

   assign rise = level_q & ~hist_q;

   // Enable mask register; a write is visible to the next candidate evaluation
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mask_q <= '1;
      end else if (mask_we_i) begin
         mask_q <= mask_i;
      end
   end

   // Edge lines latch until accepted (a new edge beats the clear); level lines follow the input
   always_comb begin
      pending_d = '0;
      for (int i = 0; i < NUM_IRQS; i++) begin
         if (EDGE_MASK[i]) begin
            pending_d[i] = rise[i] | (pending_q[i] & ~clear[i]);
         end else begin
            pending_d[i] = level_q[i];
         end
      end
   end

   // Pending status register
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign cand = pending_q & mask_q;

   // Priority encoder: scan from the top so the lowest enabled index wins
   always_comb begin
      win_num = '0;
      for (int i = NUM_IRQS - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win_num = IRQ_NUM_W'(i);
         end
      end
   end

   // Acceptance clears the pending bit of the line being handed to the decoder
   always_comb begin
      clear = '0;
      if (accept) begin
         clear[num_q] = 1'b1;
      end
   end

   // Next-state and registered-output values for the request/service sequencer
   always_comb begin
      state_d = state_q;
      irq_d   = irq_q;
      num_d   = num_q;
      svc_d   = svc_q;
      accept  = 1'b0;
      case (state_q)
         IRQ_IDLE: begin
            if (|cand) begin
               irq_d   = 1'b1;
               num_d   = win_num;
               state_d = IRQ_REQ;
            end
         end
         IRQ_REQ: begin
            if (en_i) begin
               accept  = 1'b1;
               irq_d   = 1'b0;
               svc_d   = 1'b1;
               state_d = IRQ_SERVICE;
            end
         end
         IRQ_SERVICE: begin
            if (en_i && eoi_i) begin
               svc_d   = 1'b0;
               state_d = IRQ_IDLE;
            end
         end
         default: begin
            irq_d   = 1'b0;
            svc_d   = 1'b0;
            state_d = IRQ_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any request or handler in flight
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IRQ_IDLE;
         irq_q   <= 1'b0;
         num_q   <= '0;
         svc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         irq_q   <= irq_d;
         num_q   <= num_d;
         svc_q   <= svc_d;
      end
   end

   assign irq_o        = irq_q;
   assign irq_num_o    = num_q;
   assign pending_o    = pending_q;
   assign in_service_o = svc_q;

endmodule
